// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART core and its helpers.
//   - parity encodings used by the PARITY build option
//   - TX/RX FSM state types
//   - counter-width constants and helper
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Widest legal character; the data-bit counter is sized for it.
    localparam int unsigned MAX_DATA_BITS = 9;
    localparam int unsigned BIT_CNT_W     = $clog2(MAX_DATA_BITS + 1);

    typedef enum logic [2:0] {
        TxIdle   = 3'd0,
        TxStart  = 3'd1,
        TxData   = 3'd2,
        TxParity = 3'd3,
        TxStop   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle     = 3'd0,
        RxStart    = 3'd1,
        RxData     = 3'd2,
        RxParity   = 3'd3,
        RxStop     = 3'd4,
        RxWaitHigh = 3'd5
    } rx_state_e;

    // Counter width for a count range of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-cycle tick every DIV_COUNT clocks.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (counter returns to 0)
//   tick_o : high for one cycle when the count is DIV_COUNT-1
module uart_baud_gen #(
    parameter int unsigned DIV_COUNT = 44
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(DIV_COUNT);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_COUNT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CntLast);
        cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with shared oversample tick, framed TX and midpoint-sampling RX.
//   clk, rst                   : clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready  : transmit handshake
//   serial_tx, serial_rx       : line pins (idle high)
//   loopback                   : internal TX line feeds RX, serial_tx held high
//   rx_data/rx_valid           : received character and one-cycle strobe
//   rx_frame_err/rx_parity_err : error flags, qualified by rx_valid
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned DIV_COUNT  = 44,
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_tx,
    input  logic                 serial_rx,
    input  logic                 loopback,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int unsigned OsW = cnt_width(OVERSAMPLE);
    localparam logic [OsW-1:0]       OsLast     = OsW'(OVERSAMPLE - 1);
    localparam logic [OsW-1:0]       OsHalfLast = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] BitLast    = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic StopLast = (STOP_BITS == 2);
    localparam logic ParOn    = (PARITY != PAR_NONE);
    localparam logic ParOdd   = (PARITY == PAR_ODD);

    logic tick;

    uart_baud_gen #(.DIV_COUNT(DIV_COUNT)) u_baud (
        .clk_i  (clk),
        .rst_ni (rst),
        .tick_o (tick)
    );

    // ---------------- Transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic                 tx_pend_q, tx_pend_d;   // accepted, waiting for the next tick
    logic [OsW-1:0]       tx_os_q, tx_os_d;
    logic [BIT_CNT_W-1:0] tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_line_q, tx_line_d;

    assign tx_ready  = (tx_state_q == TxIdle) && !tx_pend_q;
    assign serial_tx = tx_line_q | loopback;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_pend_d  = tx_pend_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        // Line changes happen only on the tick closing the last oversample of a bit.
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_valid && tx_ready) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ ParOdd;
                    tx_pend_d  = 1'b1;
                end else if (tx_pend_q && tick) begin
                    tx_pend_d  = 1'b0;
                    tx_state_d = TxStart;
                    tx_line_d  = 1'b0;
                    tx_os_d    = '0;
                end
            end
            TxStart: begin
                if (tick) begin
                    if (tx_os_q == OsLast) begin
                        tx_state_d = TxData;
                        tx_line_d  = tx_shift_q[0];
                        tx_os_d    = '0;
                        tx_bit_d   = '0;
                    end else begin
                        tx_os_d = tx_os_q + OsW'(1);
                    end
                end
            end
            TxData: begin
                if (tick) begin
                    if (tx_os_q == OsLast) begin
                        tx_os_d = '0;
                        if (tx_bit_q == BitLast) begin
                            tx_state_d = ParOn ? TxParity : TxStop;
                            tx_line_d  = ParOn ? tx_par_q : 1'b1;
                            tx_stop_d  = 1'b0;
                        end else begin
                            tx_bit_d   = tx_bit_q + BIT_CNT_W'(1);
                            tx_line_d  = tx_shift_q[1];
                            tx_shift_d = tx_shift_q >> 1;
                        end
                    end else begin
                        tx_os_d = tx_os_q + OsW'(1);
                    end
                end
            end
            TxParity: begin
                if (tick) begin
                    if (tx_os_q == OsLast) begin
                        tx_state_d = TxStop;
                        tx_line_d  = 1'b1;
                        tx_os_d    = '0;
                        tx_stop_d  = 1'b0;
                    end else begin
                        tx_os_d = tx_os_q + OsW'(1);
                    end
                end
            end
            TxStop: begin
                if (tick) begin
                    if (tx_os_q == OsLast) begin
                        tx_os_d = '0;
                        if (tx_stop_q == StopLast) tx_state_d = TxIdle;
                        else                       tx_stop_d  = 1'b1;
                    end else begin
                        tx_os_d = tx_os_q + OsW'(1);
                    end
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_pend_q  <= 1'b0;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_pend_q  <= tx_pend_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // ---------------- Receiver ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic                 rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d;
    logic [OsW-1:0]       rx_os_q, rx_os_d;
    logic [BIT_CNT_W-1:0] rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d, rx_perr_q, rx_perr_d;

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;

    always_comb begin
        rx_sync1_d = loopback ? tx_line_q : serial_rx;
        rx_sync2_d = rx_sync1_q;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        if (tick) begin
            unique case (rx_state_q)
                RxIdle: begin
                    if (!rx_sync2_q) begin
                        rx_state_d = RxStart;
                        rx_os_d    = '0;
                    end
                end
                RxStart: begin
                    // Half a bit after detection: still low means a real start bit.
                    if (rx_os_q == OsHalfLast) begin
                        rx_state_d = rx_sync2_q ? RxIdle : RxData;
                        rx_os_d    = '0;
                        rx_bit_d   = '0;
                    end else begin
                        rx_os_d = rx_os_q + OsW'(1);
                    end
                end
                RxData: begin
                    if (rx_os_q == OsLast) begin
                        rx_os_d    = '0;
                        rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BitLast) rx_state_d = ParOn ? RxParity : RxStop;
                        else                     rx_bit_d   = rx_bit_q + BIT_CNT_W'(1);
                    end else begin
                        rx_os_d = rx_os_q + OsW'(1);
                    end
                end
                RxParity: begin
                    if (rx_os_q == OsLast) begin
                        rx_os_d    = '0;
                        rx_par_d   = rx_sync2_q;
                        rx_state_d = RxStop;
                    end else begin
                        rx_os_d = rx_os_q + OsW'(1);
                    end
                end
                RxStop: begin
                    if (rx_os_q == OsLast) begin
                        rx_os_d    = '0;
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_ferr_d  = !rx_sync2_q;
                        rx_perr_d  = ParOn && (((^rx_shift_q) ^ rx_par_q) != ParOdd);
                        // A low stop bit may be a break: wait for the line to recover.
                        rx_state_d = rx_sync2_q ? RxIdle : RxWaitHigh;
                    end else begin
                        rx_os_d = rx_os_q + OsW'(1);
                    end
                end
                RxWaitHigh: begin
                    if (rx_sync2_q) rx_state_d = RxIdle;
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RxIdle;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scenario bench for uart_core (DIV_COUNT=4, OVERSAMPLE=8 => 32 cycles per bit).
// Instance dut is 8N1, instance dut_p is 8E1 (used for loopback).
module tb_uart_core;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_data = '0, tx_data_p = '0;
    logic tx_valid = 1'b0, tx_valid_p = 1'b0;
    logic serial_rx = 1'b1, serial_rx_p = 1'b1;
    logic loopback = 1'b0, loopback_p = 1'b0;
    logic tx_ready, tx_ready_p, serial_tx, serial_tx_p;
    logic [7:0] rx_data, rx_data_p;
    logic rx_valid, rx_valid_p, rx_frame_err, rx_frame_err_p, rx_parity_err, rx_parity_err_p;

    uart_core #(.DIV_COUNT(4), .OVERSAMPLE(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .serial_tx(serial_tx), .serial_rx(serial_rx), .loopback(loopback),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err)
    );

    uart_core #(.DIV_COUNT(4), .OVERSAMPLE(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_valid(tx_valid_p),
        .tx_ready(tx_ready_p), .serial_tx(serial_tx_p), .serial_rx(serial_rx_p),
        .loopback(loopback_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_frame_err(rx_frame_err_p), .rx_parity_err(rx_parity_err_p)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q_a[$];
    exp_t q_p[$];
    int   rx_cnt_a = 0;
    int   rx_cnt_p = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receive scoreboards: every strobe must match the oldest pushed expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rx_valid === 1'b1) begin
            rx_cnt_a++;
            tests++;
            if (q_a.size() == 0) begin
                fails++;
                $display("FAIL rx_unexpected data=%h fe=%b", rx_data, rx_frame_err);
            end else begin
                e = q_a.pop_front();
                if ({rx_data, rx_frame_err, rx_parity_err} !== {e.data, e.fe, e.pe}) begin
                    fails++;
                    $display("FAIL rx_char got=%h/%b/%b exp=%h/%b/%b", rx_data, rx_frame_err,
                             rx_parity_err, e.data, e.fe, e.pe);
                end
            end
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rx_valid_p === 1'b1) begin
            rx_cnt_p++;
            tests++;
            if (q_p.size() == 0) begin
                fails++;
                $display("FAIL rx_p_unexpected data=%h", rx_data_p);
            end else begin
                e = q_p.pop_front();
                if ({rx_data_p, rx_frame_err_p, rx_parity_err_p} !== {e.data, e.fe, e.pe}) begin
                    fails++;
                    $display("FAIL rx_p_char got=%h/%b/%b exp=%h/%b/%b", rx_data_p,
                             rx_frame_err_p, rx_parity_err_p, e.data, e.fe, e.pe);
                end
            end
        end
    end

    task automatic test_reset();
        logic seen_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            serial_rx = ~serial_rx;
            serial_rx_p = ~serial_rx_p;
            step();
            if (rx_valid !== 1'b0 || rx_valid_p !== 1'b0) seen_valid = 1'b1;
        end
        tests++;
        if (serial_tx !== 1'b1 || serial_tx_p !== 1'b1) begin
            fails++;
            $display("FAIL reset_serial_tx got=%b/%b exp=1", serial_tx, serial_tx_p);
        end
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_tx_ready got=%b exp=1", tx_ready);
        end
        tests++;
        if (seen_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_rx_valid got=%b exp=0", seen_valid);
        end
        tests++;
        if ({rx_data, rx_frame_err, rx_parity_err} !== 10'd0) begin
            fails++;
            $display("FAIL reset_rx_regs got=%h/%b/%b exp=0", rx_data, rx_frame_err,
                     rx_parity_err);
        end
        serial_rx = 1'b1;
        serial_rx_p = 1'b1;
        rst = 1'b1;
        step();
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_tx_ready got=%b exp=1", tx_ready);
        end
        repeat (8) step();
    endtask

    task automatic test_tx_8n1();
        logic [9:0] frame = {1'b1, 8'hA5, 1'b0};
        int n = 0;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL tx_accept_ready got=%b exp=0", tx_ready);
        end
        while (serial_tx === 1'b1 && n < 10) begin
            step();
            n++;
        end
        tests++;
        if (n < 1 || n > 4) begin
            fails++;
            $display("FAIL tx_start_latency got=%0d exp=1..4", n);
            return;
        end
        for (int off = 1; off <= 320; off++) begin
            step();
            if (off < 320 && (off % 32 == 1 || off % 32 == 31)) begin
                tests++;
                if (serial_tx !== frame[off/32]) begin
                    fails++;
                    $display("FAIL tx_bit off=%0d got=%b exp=%b", off, serial_tx, frame[off/32]);
                end
            end
            if (off == 319) begin
                tests++;
                if (tx_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL tx_ready_end got=%b exp=0", tx_ready);
                end
            end
            if (off == 320) begin
                tests++;
                if (tx_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL tx_ready_rise got=%b exp=1", tx_ready);
                end
            end
        end
        repeat (16) step();
    endtask

    task automatic test_loopback_8e1();
        int   start = rx_cnt_p;
        int   n = 0;
        logic line_bad = 1'b0;
        loopback_p = 1'b1;
        step();
        q_p.push_back('{data: 8'h37, fe: 1'b0, pe: 1'b0});
        tx_data_p = 8'h37;
        tx_valid_p = 1'b1;
        step();
        tx_valid_p = 1'b0;
        while (dut_p.tx_line_q === 1'b1 && n < 10) begin
            if (serial_tx_p !== 1'b1) line_bad = 1'b1;
            step();
            n++;
        end
        tests++;
        if (n >= 10) begin
            fails++;
            $display("FAIL lb_start got=timeout exp=start bit");
        end
        for (int off = 1; off <= 9 * 32 + 16; off++) begin
            step();
            if (serial_tx_p !== 1'b1) line_bad = 1'b1;
        end
        tests++;
        if (dut_p.tx_line_q !== 1'b1) begin
            fails++;
            $display("FAIL lb_parity_bit got=%b exp=1", dut_p.tx_line_q);
        end
        n = 0;
        while (rx_cnt_p == start && n < 200) begin
            step();
            if (serial_tx_p !== 1'b1) line_bad = 1'b1;
            n++;
        end
        repeat (40) begin
            step();
            if (serial_tx_p !== 1'b1) line_bad = 1'b1;
        end
        tests++;
        if (rx_cnt_p != start + 1 || q_p.size() != 0) begin
            fails++;
            $display("FAIL lb_strobes got=%0d exp=1", rx_cnt_p - start);
        end
        tests++;
        if (line_bad !== 1'b0) begin
            fails++;
            $display("FAIL lb_serial_tx_high got=low exp=high");
        end
        loopback_p = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_rx_glitch();
        int start = rx_cnt_a;
        serial_rx = 1'b0;
        repeat (12) step();
        serial_rx = 1'b1;
        repeat (100) step();
        tests++;
        if (rx_cnt_a != start) begin
            fails++;
            $display("FAIL glitch_strobes got=%0d exp=0", rx_cnt_a - start);
        end
        tests++;
        if (dut.rx_state_q !== RxIdle) begin
            fails++;
            $display("FAIL glitch_idle got=%0d exp=%0d", dut.rx_state_q, RxIdle);
        end
    endtask

    task automatic drive_bit(input logic v);
        serial_rx = v;
        repeat (32) step();
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_break();
        int start = rx_cnt_a;
        q_a.push_back('{data: 8'h55, fe: 1'b1, pe: 1'b0});
        drive_frame(8'h55, 1'b0);
        serial_rx = 1'b0;
        repeat (3 * 320) step();
        tests++;
        if (rx_cnt_a != start + 1) begin
            fails++;
            $display("FAIL break_strobes got=%0d exp=1", rx_cnt_a - start);
        end
        serial_rx = 1'b1;
        repeat (64) step();
        q_a.push_back('{data: 8'h0F, fe: 1'b0, pe: 1'b0});
        drive_frame(8'h0F, 1'b1);
        repeat (64) step();
        tests++;
        if (rx_cnt_a != start + 2 || q_a.size() != 0) begin
            fails++;
            $display("FAIL break_recover got=%0d exp=2 pending=%0d", rx_cnt_a - start,
                     q_a.size());
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int rise_t = 0;
        int gap = 0;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        while (serial_tx === 1'b1 && n < 10) begin
            step();
            n++;
        end
        n = 0;
        while (serial_tx === 1'b0 && n < 400) begin
            step();
            n++;
        end
        rise_t = n;
        while (serial_tx === 1'b1 && n < 500) begin
            step();
            n++;
        end
        gap = n - rise_t;
        tests++;
        if (gap < 33 || gap > 36) begin
            fails++;
            $display("FAIL b2b_gap got=%0d exp=33..36", gap);
        end
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_accept got=%b exp=0", tx_ready);
        end
        tx_valid = 1'b0;
        repeat (10) step();
        tests++;
        if (serial_tx !== 1'b0) begin
            fails++;
            $display("FAIL b2b_start_bit got=%b exp=0", serial_tx);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (serial_tx !== 1'b1 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_frame got=%b/%b exp=1/1", serial_tx, tx_ready);
        end
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback_8e1();
        test_rx_glitch();
        test_break();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART transceiver: oversampled baud generation, framed transmit with a valid/ready handshake, and a glitch-filtering receiver with midpoint sampling and error flags. It replaces the fixed-rate pass-through serial logic in the FPGA top level. The character format (data width, parity, stop bits) and the baud divisor are build-time options. An internal loopback mode supports board bring-up without external wiring.

## Interface
- DIV_COUNT, 44: clk cycles per oversample tick. 40 MHz / 44 ≈ 8 × 115200. Legal range ≥ 2.
- OVERSAMPLE, 8: ticks per bit. Must be even, ≥ 4.
- DATA_BITS, 8: data bits per character, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- clk in 1: sole clock.
- rst in 1: asynchronous, active-low reset.
- tx_data in DATA_BITS: character to send. Sampled on handshake.
- tx_valid in 1: transmit request.
- tx_ready out 1: transmitter can accept a character.
- serial_tx out 1: line output. Idle high.
- serial_rx in 1: line input. Asynchronous to clk.
- loopback in 1: 1 routes the internal TX line into the RX path and forces serial_tx high.
- rx_data out DATA_BITS: last received character. Held until the next receive.
- rx_valid out 1: one-cycle strobe, new rx_data.
- rx_frame_err out 1: qualified by rx_valid. Stop bit sampled low.
- rx_parity_err out 1: qualified by rx_valid. Parity mismatch. Always 0 when PARITY = 0.

## Operation
- Tick generator: free-running counter 0..DIV_COUNT-1. `tick` is high for one cycle when the count is DIV_COUNT-1, then the counter wraps to 0. TX and RX share the tick.
- TX FSM states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
  - Handshake: accept when tx_valid && tx_ready. This latches tx_data into the shift register and drops tx_ready on the next edge.
  - Frame: bits go out LSB first. Each bit lasts exactly OVERSAMPLE ticks. STOP lasts STOP_BITS × OVERSAMPLE ticks.
  - tx_ready rises in the cycle after the last stop tick. Back-to-back characters therefore have no idle gap beyond tick alignment.
  - Odd parity makes the count of ones in data+parity odd. Even parity makes it even.
- RX path:
  - Input is a 2-flop synchronizer whose flops reset to 1. The mux (loopback ? internal tx line : serial_rx) sits before the synchronizer.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE → START on a tick that sees the synchronized line low.
  - START: count OVERSAMPLE/2 ticks, then resample. Low → DATA. High → IDLE (glitch rejected, no strobe).
  - DATA / PARITY / STOP: sample once every OVERSAMPLE ticks, i.e. at bit midpoints. Only the first stop bit is checked.
  - On the stop sample: update rx_data, pulse rx_valid with both error flags, then go to IDLE. If the stop bit was low, go to WAIT_HIGH instead; WAIT_HIGH leaves for IDLE when the line reads high on a tick. A break therefore yields exactly one strobe.
- No RX backpressure. A character not consumed before the next strobe is overwritten.
- loopback may toggle at any time. An in-flight frame may end in a glitch reject or a framing error. The block must never lock up and must return to IDLE within one frame time.

## Timing
- Values in reset: serial_tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, error flags = 0, both FSMs IDLE, tick counter = 0.
- Reset release: tx_ready is usable in the first cycle after release.
- TX latency: serial_tx falls on the clk edge after the first tick following acceptance, i.e. 1..DIV_COUNT cycles later. serial_tx is registered.
- RX latency: rx_valid is asserted 1 cycle after the tick that samples the stop bit. From the line falling edge this is about 2 sync cycles + (OVERSAMPLE/2 + (DATA_BITS + P + 1) × OVERSAMPLE) ticks, where P = 1 if parity is enabled, else 0.
- Simultaneous events: the cycle tx_ready rises may also accept a new character. A receive strobe and a TX accept in the same cycle are independent.
- Asynchronous reset mid-frame: serial_tx goes high at once and any partial RX character is discarded.

## Structure
- Shared package uart_pkg:
  - parity encoding constants (PAR_NONE, PAR_ODD, PAR_EVEN);
  - TX and RX state enums;
  - localparams for the bit-count widths ($clog2 of DATA_BITS+1 and of OVERSAMPLE).
- Sub-module uart_baud_gen: the DIV_COUNT tick generator, kept reusable for future SPI/I2C dividers.
- TX and RX FSMs live in uart_core.

## Test plan
All scenarios use DIV_COUNT = 4 and OVERSAMPLE = 8, so one bit is 32 cycles.
- Reset: hold rst low with serial_rx toggling → serial_tx = 1, tx_ready = 1, no rx_valid.
- TX 8N1: send 0xA5 → serial_tx line is 0, 1,0,1,0,0,1,0,1, 1, each bit 32 cycles. tx_ready is low for 320 cycles after acceptance.
- Loopback 8E1: PARITY = 2, loopback = 1, send 0x37 → one rx_valid with rx_data = 0x37 and both error flags 0. Parity bit on the line is 1 (five ones). serial_tx stays 1 throughout.
- RX glitch: drive serial_rx low for 12 cycles (3 ticks), then high → no rx_valid and the FSM returns to IDLE.
- Framing/break: drive 0x55 with a low stop bit, then hold low for 3 frames → exactly one rx_valid with rx_frame_err = 1. The next valid 0x0F after the line goes high is received cleanly.
- Back-to-back TX: hold tx_valid high with 0x00 then 0xFF → start bits are contiguous (≤ 4 cycles between stop end and next start). Reset asserted mid-second frame forces serial_tx to 1 within the same cycle.
